// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared definitions for the snooping coherence bus arbiter:
// bus operation encodings, FSM state encodings and a one-hot decode helper.
package coherence_bus_arbiter_pkg;

  // Upper bound on the number of cache requesters the arbiter supports
  localparam int MAX_CPUS = 8;

  // Bus operations carried on req_op / snoop_op
  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_WB   = 2'b11
  } bus_op_e;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SNOOP = 2'b01,
    MEM   = 2'b10,
    RESP  = 2'b11
  } bus_state_e;

  // Index of the set bit in a one-hot vector (0 when the vector is empty)
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_CPUS-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_CPUS; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/coherence_bus_arbiter_rr_arbiter.sv
// Round-robin requester selection. Purely combinational: the search starts
// at the index after ptr (the last CPU served) and wraps around, so the CPU
// that was just served has the lowest priority.
module rr_arbiter
  import coherence_bus_arbiter_pkg::*;
#(
  parameter int NUM_CPUS = 4,
  parameter int PTR_W    = 2
) (
  input  logic [NUM_CPUS-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_CPUS-1:0] gnt
);

  // Scan requesters from ptr+1 upward with wrap; first requester found wins
  always_comb begin
    logic found_s;
    int   idx_s;
    gnt     = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 1; i <= NUM_CPUS; i++) begin
      idx_s = int'(ptr) + i;
      if (idx_s >= NUM_CPUS) begin
        idx_s = idx_s - NUM_CPUS;
      end else begin
        idx_s = idx_s;
      end
      if (req[idx_s] && !found_s) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Snooping coherence bus arbiter. Grants one cache at a time (round-robin),
// broadcasts a one-cycle snoop, falls back to memory when no cache supplies
// the line, and returns a one-cycle response.
// Optional feature macro: COH_BUS_TIMEOUT_EN -- adds a memory-ack watchdog
// that aborts the MEM phase after TIMEOUT_CYCLES cycles with resp_error=1.
// All outputs are registered; their values are decoded from the next state
// so they line up with the state they belong to.
module coherence_bus_arbiter
  import coherence_bus_arbiter_pkg::*;
#(
  parameter int NUM_CPUS       = 4,
  parameter int TAG_WIDTH      = 20,
  parameter int LINE_BITS      = 256,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CPUS-1:0]           req,
  input  logic [2*NUM_CPUS-1:0]         req_op,
  input  logic [NUM_CPUS*TAG_WIDTH-1:0] req_tag,
  input  logic [NUM_CPUS*LINE_BITS-1:0] req_wdata,
  output logic [NUM_CPUS-1:0]           gnt,
  output logic                          done,
  output logic                          snoop_valid,
  output logic [1:0]                    snoop_op,
  output logic [TAG_WIDTH-1:0]          snoop_tag,
  output logic [NUM_CPUS-1:0]           snoop_en,
  input  logic [NUM_CPUS-1:0]           snoop_hit,
  input  logic [NUM_CPUS-1:0]           snoop_supply,
  input  logic [NUM_CPUS*LINE_BITS-1:0] snoop_data,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [TAG_WIDTH-1:0]          mem_tag,
  output logic [LINE_BITS-1:0]          mem_wdata,
  input  logic                          mem_ack,
  input  logic [LINE_BITS-1:0]          mem_rdata,
  output logic                          resp_valid,
  output logic [LINE_BITS-1:0]          resp_data,
  output logic                          resp_exclusive,
  output logic                          resp_error
);

  localparam int PTR_W = $clog2(NUM_CPUS);
  // After reset the pointer names the last CPU so CPU0 is searched first
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_CPUS - 1);

  // Elaboration-time guard on the configuration range
  if (NUM_CPUS < 2 || NUM_CPUS > MAX_CPUS || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("coherence_bus_arbiter: unsupported NUM_CPUS/TIMEOUT_CYCLES");
  end

  bus_state_e           state_r, state_nx_s;
  logic [PTR_W-1:0]     ptr_r, ptr_nx_s;
  logic [NUM_CPUS-1:0]  rr_gnt_s, gnt_nx_s;
  bus_op_e              op_r, op_nx_s;
  logic [TAG_WIDTH-1:0] tag_r, tag_nx_s;
  logic [LINE_BITS-1:0] wdata_r, wdata_nx_s;
  logic [LINE_BITS-1:0] data_r, data_nx_s;
  logic                 excl_r, excl_nx_s;
  logic [MAX_CPUS-1:0]  rr_pad_s, gnt_pad_s;
  logic [2:0]           sel_idx_s, cur_idx_s;
  logic [NUM_CPUS-1:0]  hit_m_s, supply_m_s;
  logic [LINE_BITS-1:0] supply_data_s;

  rr_arbiter #(
    .NUM_CPUS (NUM_CPUS),
    .PTR_W    (PTR_W)
  ) u_rr (
    .req (req),
    .ptr (ptr_r),
    .gnt (rr_gnt_s)
  );

  // The granted CPU does not snoop itself, so its hit/supply are ignored
  assign hit_m_s    = snoop_hit & ~gnt;
  assign supply_m_s = snoop_supply & ~gnt;

  // Indices of the newly selected CPU and of the CPU currently granted
  always_comb begin
    rr_pad_s                 = '0;
    gnt_pad_s                = '0;
    rr_pad_s[NUM_CPUS-1:0]   = rr_gnt_s;
    gnt_pad_s[NUM_CPUS-1:0]  = gnt;
    sel_idx_s                = onehot_to_idx(rr_pad_s);
    cur_idx_s                = onehot_to_idx(gnt_pad_s);
  end

  // Line supplied by the lowest-index cache that asserted snoop_supply
  always_comb begin
    logic found_s;
    supply_data_s = '0;
    found_s       = 1'b0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (supply_m_s[i] && !found_s) begin
        supply_data_s = snoop_data[i*LINE_BITS +: LINE_BITS];
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

`ifdef COH_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_r;
  logic             tmo_hit_s;
  logic             err_nx_s;

  // Watchdog fires on the last MEM cycle of the allowed window without ack
  assign tmo_hit_s = (state_r == MEM) && !mem_ack &&
                     (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_nx_s  = tmo_hit_s;

  // Count consecutive MEM cycles waiting for mem_ack; idle at zero elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if (state_r == MEM && !mem_ack && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  // Error flag accompanies the response produced by a watchdog abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_error <= 1'b0;
    end else begin
      resp_error <= (state_nx_s == RESP) && err_nx_s;
    end
  end
`else
  assign resp_error = 1'b0;
`endif

  // Next-state and transaction-context logic
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    gnt_nx_s   = gnt;
    op_nx_s    = op_r;
    tag_nx_s   = tag_r;
    wdata_nx_s = wdata_r;
    data_nx_s  = data_r;
    excl_nx_s  = excl_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          gnt_nx_s   = rr_gnt_s;
          op_nx_s    = bus_op_e'(req_op[2*int'(sel_idx_s) +: 2]);
          tag_nx_s   = req_tag[int'(sel_idx_s)*TAG_WIDTH +: TAG_WIDTH];
          wdata_nx_s = req_wdata[int'(sel_idx_s)*LINE_BITS +: LINE_BITS];
          data_nx_s  = '0;
          if (op_nx_s == BUS_WB) begin
            state_nx_s = MEM;
            excl_nx_s  = 1'b0;
          end else begin
            state_nx_s = SNOOP;
            excl_nx_s  = (op_nx_s != BUS_RD);
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      SNOOP: begin
        // A plain read is exclusive only if no other cache holds the line
        excl_nx_s = (op_r != BUS_RD) || !(|hit_m_s);
        if (op_r == BUS_UPGR) begin
          state_nx_s = RESP;
        end else if (|supply_m_s) begin
          state_nx_s = RESP;
          data_nx_s  = supply_data_s;
        end else begin
          state_nx_s = MEM;
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_nx_s = RESP;
          data_nx_s  = mem_rdata;
        end
`ifdef COH_BUS_TIMEOUT_EN
        else if (tmo_hit_s) begin
          state_nx_s = RESP;
          data_nx_s  = '0;
          excl_nx_s  = 1'b0;
        end
`endif
        else begin
          state_nx_s = MEM;
        end
      end
      RESP: begin
        state_nx_s = IDLE;
        gnt_nx_s   = '0;
        ptr_nx_s   = PTR_W'(cur_idx_s);
      end
      default: begin
        state_nx_s = IDLE;
        gnt_nx_s   = '0;
      end
    endcase
  end

  // State, pointer and latched transaction context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= PTR_RST;
      op_r    <= BUS_RD;
      tag_r   <= '0;
      wdata_r <= '0;
      data_r  <= '0;
      excl_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ptr_r   <= ptr_nx_s;
      op_r    <= op_nx_s;
      tag_r   <= tag_nx_s;
      wdata_r <= wdata_nx_s;
      data_r  <= data_nx_s;
      excl_r  <= excl_nx_s;
    end
  end

  // Registered bus outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt            <= '0;
      done           <= 1'b0;
      snoop_valid    <= 1'b0;
      snoop_op       <= 2'b00;
      snoop_tag      <= '0;
      snoop_en       <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_tag        <= '0;
      mem_wdata      <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_exclusive <= 1'b0;
    end else begin
      gnt            <= gnt_nx_s;
      done           <= (state_nx_s == RESP);
      resp_valid     <= (state_nx_s == RESP);
      resp_data      <= (state_nx_s == RESP) ? data_nx_s : '0;
      resp_exclusive <= (state_nx_s == RESP) && excl_nx_s;
      snoop_valid    <= (state_nx_s == SNOOP);
      snoop_op       <= (state_nx_s == SNOOP) ? op_nx_s : 2'b00;
      snoop_tag      <= (state_nx_s == SNOOP) ? tag_nx_s : '0;
      snoop_en       <= (state_nx_s == SNOOP) ? ~gnt_nx_s : '0;
      mem_req        <= (state_nx_s == MEM);
      mem_we         <= (state_nx_s == MEM) && (op_nx_s == BUS_WB);
      mem_tag        <= (state_nx_s == MEM) ? tag_nx_s : '0;
      mem_wdata      <= ((state_nx_s == MEM) && (op_nx_s == BUS_WB)) ? wdata_nx_s : '0;
    end
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed, table-driven bench for coherence_bus_arbiter (4 CPUs).
// Each table row is one complete bus transaction with hand-computed results;
// reset-abort and (when COH_BUS_TIMEOUT_EN is defined) watchdog behaviour
// are exercised by hand-written sequences.
module tb_coherence_bus_arbiter;
  import coherence_bus_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TW = 20;
  localparam int LB = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  req_op = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*LB-1:0] req_wdata = '0;
  logic [N-1:0]    gnt;
  logic            done;
  logic            snoop_valid;
  logic [1:0]      snoop_op;
  logic [TW-1:0]   snoop_tag;
  logic [N-1:0]    snoop_en;
  logic [N-1:0]    snoop_hit = '0;
  logic [N-1:0]    snoop_supply = '0;
  logic [N*LB-1:0] snoop_data = '0;
  logic            mem_req;
  logic            mem_we;
  logic [TW-1:0]   mem_tag;
  logic [LB-1:0]   mem_wdata;
  logic            mem_ack = 1'b0;
  logic [LB-1:0]   mem_rdata = '0;
  logic            resp_valid;
  logic [LB-1:0]   resp_data;
  logic            resp_exclusive;
  logic            resp_error;

  int n_vec = 0;
  int n_bad = 0;

  coherence_bus_arbiter #(
    .NUM_CPUS(N), .TAG_WIDTH(TW), .LINE_BITS(LB), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_op(req_op), .req_tag(req_tag), .req_wdata(req_wdata),
    .gnt(gnt), .done(done),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_tag(snoop_tag),
    .snoop_en(snoop_en), .snoop_hit(snoop_hit), .snoop_supply(snoop_supply),
    .snoop_data(snoop_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_tag(mem_tag), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_exclusive(resp_exclusive), .resp_error(resp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  op;
    logic [19:0] tag;
    logic [15:0] wpat;
    logic [3:0]  hit;
    logic [3:0]  sup;
    logic [7:0]  sup_byte;   // cache i supplies bytes of value sup_byte+i
    logic [7:0]  mem_byte;
    int          ack_dly;    // MEM cycles before mem_ack is raised
    bit          drop_req;   // withdraw req right after the grant
    logic [3:0]  e_gnt;
    bit          e_snoop;
    bit          e_mem;
    bit          e_we;
    logic [7:0]  e_data;
    bit          e_excl;
    int          e_cyc;      // transaction cycles, counting the grant decision cycle
  } vec_t;

  vec_t vt[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [3:0] g_seen;
    logic [3:0] exp_en;
    bit sn_seen, m_seen, we_seen, dn_seen, unstable;
    int mcyc, gcyc, dcyc;
    g_seen = '0; sn_seen = 0; m_seen = 0; we_seen = 0; dn_seen = 0; unstable = 0;
    mcyc = 0; gcyc = 0; dcyc = 0;
    exp_en = ~v.e_gnt;
    req = v.req;
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]     = v.e_gnt[i] ? v.op : (v.op ^ 2'b01);
      req_tag[TW*i +: TW]  = v.e_gnt[i] ? v.tag : ~v.tag;
      req_wdata[LB*i +: LB] = v.e_gnt[i] ? {16{v.wpat}} : {16{~v.wpat}};
      snoop_data[LB*i +: LB] = {32{v.sup_byte + 8'(i)}};
    end
    snoop_hit = v.hit;
    snoop_supply = v.sup;
    mem_rdata = {32{v.mem_byte}};
    mem_ack = 1'b0;
    for (int c = 0; c < 60 && !dn_seen; c++) begin
      step();
      if (gnt != 4'b0000 && g_seen == 4'b0000) begin
        g_seen = gnt;
        gcyc = c;
        if (v.drop_req) req = '0;
      end else if (g_seen != 4'b0000 && gnt !== g_seen) begin
        unstable = 1;
      end
      if (snoop_valid) begin
        sn_seen = 1;
        chk({nm, " snoop_en"}, snoop_en, exp_en);
        chk({nm, " snoop_tag"}, snoop_tag, v.tag);
        chk({nm, " snoop_op"}, snoop_op, v.op);
      end
      if (mem_req) begin
        m_seen = 1;
        if (mem_we) begin
          we_seen = 1;
          chk({nm, " mem_wdata"}, mem_wdata, {16{v.wpat}});
        end
        chk({nm, " mem_tag"}, mem_tag, v.tag);
        if (mcyc >= v.ack_dly) mem_ack = 1'b1;
        mcyc++;
      end else begin
        mem_ack = 1'b0;
      end
      if (resp_valid) begin
        dn_seen = 1;
        dcyc = c;
        chk({nm, " done"}, done, 1'b1);
        chk({nm, " resp_data"}, resp_data, {32{v.e_data}});
        chk({nm, " resp_exclusive"}, resp_exclusive, v.e_excl);
        chk({nm, " resp_error"}, resp_error, 1'b0);
      end
    end
    mem_ack = 1'b0;
    chk({nm, " completed"}, dn_seen, 1'b1);
    chk({nm, " gnt"}, g_seen, v.e_gnt);
    chk({nm, " gnt_stable"}, unstable, 1'b0);
    chk({nm, " snoop_seen"}, sn_seen, v.e_snoop);
    chk({nm, " mem_seen"}, m_seen, v.e_mem);
    chk({nm, " mem_we_seen"}, we_seen, v.e_we);
    chk({nm, " cycles"}, dcyc - gcyc + 2, v.e_cyc);
    step();
    chk({nm, " idle_gap"}, {gnt, done, resp_valid, snoop_valid, mem_req}, 8'h00);
  endtask

  initial begin
    //           req      op        tag       wpat     hit      sup      supB   memB   dly drop e_gnt   sn mem we data   ex cyc
    vt[0]  = '{4'b1111, BUS_RD,   20'h00100, 16'h0000, 4'b0000, 4'b0000, 8'h00, 8'h11, 0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 4};
    vt[1]  = '{4'b1111, BUS_RD,   20'h00101, 16'h0000, 4'b0000, 4'b0000, 8'h00, 8'h22, 0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 4};
    vt[2]  = '{4'b1111, BUS_RD,   20'h00102, 16'h0000, 4'b0000, 4'b0000, 8'h00, 8'h33, 0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 4};
    vt[3]  = '{4'b1111, BUS_RD,   20'h00103, 16'h0000, 4'b0000, 4'b0000, 8'h00, 8'h44, 0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 4};
    vt[4]  = '{4'b1111, BUS_RD,   20'h00104, 16'h0000, 4'b0000, 4'b0000, 8'h00, 8'h55, 0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 4};
    vt[5]  = '{4'b0010, BUS_RD,   20'h12345, 16'h0000, 4'b0000, 4'b0000, 8'h00, 8'hA5, 5, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 9};
    vt[6]  = '{4'b0001, BUS_RD,   20'h0BEEF, 16'h0000, 4'b0100, 4'b0100, 8'h58, 8'hFF, 0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 3};
    vt[7]  = '{4'b1000, BUS_WB,   20'h0CAFE, 16'hDEAD, 4'b0000, 4'b0000, 8'h00, 8'h33, 2, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 5};
    vt[8]  = '{4'b0110, BUS_RDX,  20'h00A0A, 16'h0000, 4'b1000, 4'b0000, 8'h00, 8'h77, 1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 5};
    vt[9]  = '{4'b0110, BUS_UPGR, 20'h00B0B, 16'h0000, 4'b0001, 4'b0000, 8'h00, 8'hEE, 0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3};
    vt[10] = '{4'b1001, BUS_RD,   20'h00C0C, 16'h0000, 4'b0001, 4'b0000, 8'h00, 8'h3C, 0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 4};
    vt[11] = '{4'b0100, BUS_RD,   20'h00D0D, 16'h0000, 4'b1010, 4'b1010, 8'h10, 8'hEE, 0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 3};

    // Reset state with no requests
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset ctrl", {gnt, done, snoop_valid, snoop_op, snoop_tag, snoop_en, mem_req,
                       mem_we, mem_tag, resp_valid, resp_exclusive, resp_error}, '0);
    chk("reset data", resp_data | mem_wdata, '0);
    step();
    chk("idle no req", {gnt, snoop_valid, mem_req, resp_valid}, 7'h00);

    for (int k = 0; k < 12; k++) begin
      run_vec(vt[k], $sformatf("v%0d", k));
    end

    // Reset in the middle of a memory phase: CPU0 granted, ack withheld
    begin
      bit m_seen, spur;
      vec_t pv;
      m_seen = 0; spur = 0;
      req = 4'b0001; req_op = '0; snoop_hit = '0; snoop_supply = '0; mem_ack = 1'b0;
      for (int c = 0; c < 10 && !m_seen; c++) begin
        step();
        if (mem_req) m_seen = 1;
      end
      chk("abort mem_req reached", m_seen, 1'b1);
      chk("abort gnt", gnt, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("abort outputs cleared", {gnt, done, snoop_valid, mem_req, mem_we, resp_valid,
                                    resp_exclusive, resp_error}, '0);
      req = '0;
      repeat (2) step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
        step();
        if (resp_valid || done || gnt != 4'b0000) spur = 1;
      end
      chk("abort no response", spur, 1'b0);
      // Pointer is back at reset: CPU2 wins over CPU3 when both ask
      pv = '{4'b1100, BUS_RD, 20'h00E0E, 16'h0000, 4'b0000, 4'b0000, 8'h00, 8'h66, 0, 1'b0,
             4'b0100, 1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 4};
      run_vec(pv, "post_reset");
    end

`ifdef COH_BUS_TIMEOUT_EN
    // Memory never acknowledges: watchdog aborts after 8 MEM cycles
    begin
      int mreq_cyc;
      bit rsp;
      vec_t nv;
      mreq_cyc = 0; rsp = 0;
      req = 4'b0001; req_op = '0; snoop_hit = '0; snoop_supply = '0; mem_ack = 1'b0;
      for (int c = 0; c < 60 && !rsp; c++) begin
        step();
        if (mem_req) mreq_cyc++;
        if (resp_valid) begin
          rsp = 1;
          chk("tmo resp_error", resp_error, 1'b1);
          chk("tmo resp_data", resp_data, '0);
          chk("tmo mem_req dropped", mem_req, 1'b0);
        end
      end
      chk("tmo completed", rsp, 1'b1);
      chk("tmo mem_req cycles", mreq_cyc, 8);
      req = '0;
      step();
      nv = '{4'b0001, BUS_RD, 20'h00F0F, 16'h0000, 4'b0000, 4'b0000, 8'h00, 8'h99, 0, 1'b0,
             4'b0001, 1'b1, 1'b1, 1'b0, 8'h99, 1'b1, 4};
      run_vec(nv, "post_tmo");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/coherence_bus_arbiter.md
COHERENCE_BUS_ARBITER -- requirements
Module: coherence_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CPUS, default 4, number of cache requesters (2..8).
REQ-002 SHALL have parameter TAG_WIDTH, default 20, line tag width.
REQ-003 SHALL have parameter LINE_BITS, default 256, cache line width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, memory-ack watchdog limit.
REQ-005 SHALL have ports: clk input 1, clock; rst_n input 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: req input NUM_CPUS, per-CPU request; req_op input 2*NUM_CPUS, op per CPU (00 BusRd, 01 BusRdX, 10 BusUpgr, 11 Writeback); req_tag input NUM_CPUS*TAG_WIDTH; req_wdata input NUM_CPUS*LINE_BITS, writeback data.
REQ-007 SHALL have ports: gnt output NUM_CPUS, one-hot grant; done output 1, transaction-complete pulse.
REQ-008 SHALL have ports: snoop_valid output 1; snoop_op output 2; snoop_tag output TAG_WIDTH; snoop_en output NUM_CPUS, per-cache snoop enable (granted CPU bit 0).
REQ-009 SHALL have ports: snoop_hit input NUM_CPUS; snoop_supply input NUM_CPUS; snoop_data input NUM_CPUS*LINE_BITS.
REQ-010 SHALL have ports: mem_req output 1; mem_we output 1; mem_tag output TAG_WIDTH; mem_wdata output LINE_BITS; mem_ack input 1; mem_rdata input LINE_BITS.
REQ-011 SHALL have ports: resp_valid output 1; resp_data output LINE_BITS; resp_exclusive output 1; resp_error output 1.

Function
REQ-012 SHALL implement FSM states IDLE, SNOOP, MEM, RESP.
REQ-013 IDLE: when any req high, SHALL grant round-robin starting at index after last granted CPU, latch op/tag/wdata, assert gnt, next state SNOOP (BusRd/BusRdX/BusUpgr) or MEM (Writeback).
REQ-014 SNOOP: SHALL assert snoop_valid/snoop_op/snoop_tag/snoop_en for exactly one cycle and sample snoop_hit/snoop_supply at that cycle's end.
REQ-015 After SNOOP: BusUpgr -> RESP; any supply -> capture lowest-index supplier's data, RESP; else -> MEM read.
REQ-016 MEM: SHALL hold mem_req, mem_we (1 only for Writeback), mem_tag, mem_wdata stable until mem_ack; on mem_ack capture mem_rdata, next RESP.
REQ-017 RESP: SHALL pulse resp_valid and done for one cycle with resp_data; then clear gnt, update round-robin pointer, return IDLE.
REQ-018 resp_exclusive SHALL be 1 for BusRdX and BusUpgr, 1 for BusRd with no snoop_hit, else 0; 0 for Writeback.
REQ-019 gnt SHALL stay constant from IDLE exit through RESP; req deassertion mid-transaction SHALL be ignored.
REQ-020 New requests arriving during a transaction SHALL wait; minimum transaction latency SHALL be 3 cycles (grant, snoop, resp) and back-to-back grants SHALL have one IDLE cycle between.
REQ-021 Single requester SHALL be re-granted repeatedly; no requester SHALL wait more than NUM_CPUS-1 transactions.

Reset
REQ-022 On rst_n low SHALL enter IDLE, all outputs 0, round-robin pointer such that CPU0 has highest priority first.
REQ-023 Reset mid-transaction SHALL abort it with no resp_valid or done pulse.

Configuration
REQ-024 With COH_BUS_TIMEOUT_EN defined: counter runs in MEM; if mem_ack absent for TIMEOUT_CYCLES cycles SHALL drop mem_req, go RESP with resp_error=1, resp_data 0.
REQ-025 Without COH_BUS_TIMEOUT_EN: MEM waits indefinitely; resp_error tied 0; no counter logic.

Structure
REQ-026 Shared package SHALL hold bus op encodings (BUS_RD, BUS_RDX, BUS_UPGR, BUS_WB) and FSM state encodings.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (req, pointer in; one-hot grant out).

Verification
REQ-028 Reset, req=4'b0000 -> gnt=0, all outputs 0, state IDLE.
REQ-029 req=4'b1111 all BusRd, memory ack immediately -> grant order CPU0,1,2,3,0.
REQ-030 CPU1 BusRd tag 0x12345, no hits, mem_ack after 5 cycles, mem_rdata=0xA5..A5 -> resp_data 0xA5..A5, resp_exclusive=1, snoop_en=4'b1101.
REQ-031 CPU0 BusRd, CPU2 snoop_hit and snoop_supply with data 0x5A..5A -> no mem_req, resp_data 0x5A..5A, resp_exclusive=0, done 3 cycles after grant.
REQ-032 CPU3 Writeback data 0xDEAD.. -> no snoop_valid, mem_we=1, mem_wdata 0xDEAD.., done after ack.
REQ-033 COH_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ack never -> mem_req drops after 8 cycles, resp_error=1, next request granted normally.
